fifo_rr_arbiter: RTL and testbench

Round-robin read scheduler that drains four per-class input FIFOs into a single downstream FIFO. Only it drives the input FIFOs' pop lines and the downstream push line. It honours each FIFO's empty/almost-empty flags and the downstream almost-full/full flags, and it flags overflow as a sticky error. It sits between the four lane FIFOs and the shared output FIFO of the module.

---
 rtl/fifo_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin read scheduler draining four lane FIFOs into
// one downstream FIFO. Pops are registered, and each granted lane index rides a
// two-stage pipeline. The lane word is captured into data_out when the index
// reaches the end of stage 2.
// Overflow (stage-2 word meeting down_full) is sticky until reset.
module fifo_rr_arbiter #(
    parameter int data_width = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              fifo_empty,
    input  logic [3:0]              fifo_almost_empty,
    input  logic [4*data_width-1:0] fifo_data_in,
    input  logic                    down_almost_full,
    input  logic                    down_full,
    output logic [3:0]              fifo_pop,
    output logic                    push_out,
    output logic [data_width-1:0]   data_out,
    output logic [1:0]              state,
    output logic                    error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t                cur_state;
    state_t                next_state;
    logic [1:0]            last_grant;
    logic [1:0]            holdoff [4];
    logic                  s1_valid;
    logic                  s2_valid;
    logic [1:0]            s1_lane;
    logic [1:0]            s2_lane;
    logic [3:0]            eligible;
    logic                  overflow;
    logic                  grant_valid;
    logic [1:0]            grant_lane;
    logic [1:0]            cand;
    logic [3:0]            pop_next;
    logic                  push_next;
    logic [data_width-1:0] lane_word [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign lane_word[g] = fifo_data_in[g*data_width +: data_width];
    end

    assign state = cur_state;

    // Lane eligibility; an overflow this edge also blocks a new pop
    always_comb begin
        overflow = s2_valid && down_full;
        eligible = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            eligible[i[1:0]] = enable && !fifo_empty[i[1:0]] && (holdoff[i[1:0]] == 2'd0)
                               && !down_almost_full && (cur_state != ERROR) && !overflow;
        end
    end

    // Round-robin search starting just after last_grant; 2-bit add wraps mod 4
    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_grant + k[1:0];
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_lane  = cand;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) cur_state <= IDLE;
        else        cur_state <= next_state;
    end

    // FSM next-state: ERROR is absorbing, STALL follows almost-full, else by grant
    always_comb begin
        next_state = cur_state;
        if (cur_state == ERROR || overflow) next_state = ERROR;
        else if (down_almost_full)          next_state = STALL;
        else if (grant_valid)               next_state = ACTIVE;
        else                                next_state = IDLE;
    end

    // FSM outputs: next pop vector and push decision, registered below
    always_comb begin
        pop_next = '0;
        if (grant_valid) pop_next[grant_lane] = 1'b1;
        push_next = s2_valid && !overflow && (cur_state != ERROR);
    end

    // Registered outputs, pipeline, pointer and hold-off counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_pop   <= '0;
            push_out   <= 1'b0;
            data_out   <= '0;
            error      <= 1'b0;
            last_grant <= 2'd3;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_lane    <= '0;
            s2_lane    <= '0;
            for (int unsigned i = 0; i < 4; i++) holdoff[i[1:0]] <= '0;
        end else begin
            fifo_pop <= pop_next;
            push_out <= push_next;
            if (push_next)   data_out   <= lane_word[s2_lane];
            if (overflow)    error      <= 1'b1;
            if (grant_valid) last_grant <= grant_lane;
            s1_valid <= grant_valid;
            s1_lane  <= grant_lane;
            s2_valid <= s1_valid;
            s2_lane  <= s1_lane;
            for (int unsigned i = 0; i < 4; i++) begin
                if (grant_valid && grant_lane == i[1:0] && fifo_almost_empty[i[1:0]])
                    holdoff[i[1:0]] <= 2'd2;
                else if (holdoff[i[1:0]] != 2'd0)
                    holdoff[i[1:0]] <= holdoff[i[1:0]] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Testbench for fifo_rr_arbiter: directed scenarios followed by random
// stimulus, checked every cycle against a transaction-level reference model.
module tb_fifo_rr_arbiter;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [3:0]     fifo_empty;
    logic [3:0]     fifo_almost_empty;
    logic [4*W-1:0] fifo_data_in;
    logic           down_almost_full;
    logic           down_full;
    logic [3:0]     fifo_pop;
    logic           push_out;
    logic [W-1:0]   data_out;
    logic [1:0]     state;
    logic           error;

    // Bench-side lane FIFOs: each word is a function of lane and read count
    logic [W-1:0] lane_data [4];
    int           lane_base [4];
    int           dut_cnt [4];
    logic [3:0]   prev_pop;

    // Reference model state
    typedef struct {
        int           lane;
        int           due;
        logic [W-1:0] word;
    } flight_t;
    flight_t      inflight[$];
    int           n_edge;
    int           m_last;
    int           m_hold [4];
    int           mdl_cnt [4];
    logic [3:0]   m_pop;
    logic         m_push;
    logic [W-1:0] m_data;
    int           m_state;
    logic         m_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_a;
    int cnt_b;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign fifo_data_in[g*W +: W] = lane_data[g];
    end

    fifo_rr_arbiter #(.data_width(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .fifo_empty       (fifo_empty),
        .fifo_almost_empty(fifo_almost_empty),
        .fifo_data_in     (fifo_data_in),
        .down_almost_full (down_almost_full),
        .down_full        (down_full),
        .fifo_pop         (fifo_pop),
        .push_out         (push_out),
        .data_out         (data_out),
        .state            (state),
        .error            (error)
    );

    function automatic logic [W-1:0] word_of(int lane, int c);
        int v;
        v = lane_base[lane] + c * 37;
        return W'(v);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, from the inputs sampled at the edge
    task automatic model_edge();
        flight_t fl;
        int      g;
        int      idx;
        n_edge++;
        if (!reset) begin
            m_pop   = '0;
            m_push  = 1'b0;
            m_data  = '0;
            m_state = 0;
            m_err   = 1'b0;
            m_last  = 3;
            for (int i = 0; i < 4; i++) m_hold[i] = 0;
            inflight.delete();
            return;
        end
        m_push = 1'b0;
        if (inflight.size() > 0 && inflight[0].due == n_edge) begin
            fl = inflight.pop_front();
            if (!m_err) begin
                if (down_full) m_err = 1'b1;
                else begin
                    m_push = 1'b1;
                    m_data = fl.word;
                end
            end
        end
        g = -1;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (g < 0 && enable && !fifo_empty[idx] && m_hold[idx] == 0 &&
                !down_almost_full && !m_err)
                g = idx;
        end
        for (int i = 0; i < 4; i++) if (m_hold[i] > 0) m_hold[i]--;
        m_pop = '0;
        if (g >= 0) begin
            m_pop[g] = 1'b1;
            m_last = g;
            if (fifo_almost_empty[g]) m_hold[g] = 2;
            inflight.push_back('{lane: g, due: n_edge + 2, word: word_of(g, mdl_cnt[g])});
            mdl_cnt[g]++;
        end
        if (m_err)                 m_state = 3;
        else if (down_almost_full) m_state = 2;
        else if (g >= 0)           m_state = 1;
        else                       m_state = 0;
    endtask

    // Advance one cycle: model at the rising edge, compare on the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("fifo_pop", 32'(fifo_pop), 32'(m_pop));
        chk("push_out", 32'(push_out), 32'(m_push));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("state",    32'(state),    32'(m_state));
        chk("error",    32'(error),    32'(m_err));
        // lane FIFO read on the edge that sampled last cycle's pop
        for (int i = 0; i < 4; i++) begin
            if (prev_pop[i]) begin
                lane_data[i] = word_of(i, dut_cnt[i]);
                dut_cnt[i]++;
            end
        end
        prev_pop = fifo_pop;
    endtask

    initial begin
        lane_base[0] = 'h0a0; lane_base[1] = 'h1b0;
        lane_base[2] = 'h2c5; lane_base[3] = 'h311;
        for (int i = 0; i < 4; i++) begin
            dut_cnt[i]   = 0;
            mdl_cnt[i]   = 0;
            lane_data[i] = '0;
        end
        prev_pop = '0;
        n_edge   = 0;
        reset = 1'b0; enable = 1'b0; fifo_empty = 4'b1111; fifo_almost_empty = 4'b0000;
        down_almost_full = 1'b0; down_full = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pop",   32'(fifo_pop), 32'd0);

        // All lanes non-empty, no almost-empty: strict rotation from lane 0
        reset = 1'b1; enable = 1'b1; fifo_empty = 4'b0000;
        tick();
        chk("rr_first_pop", 32'(fifo_pop), 32'd1);
        for (int n = 0; n < 8; n++) tick();
        chk("rr_active", 32'(state), 32'd1);

        // Drain, then a single-word lane 2 with almost-empty set
        fifo_empty = 4'b1111;
        for (int n = 0; n < 4; n++) tick();
        lane_base[2] = 'h155 - mdl_cnt[2] * 37;
        fifo_empty = 4'b1011; fifo_almost_empty = 4'b0100;
        cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 7; n++) begin
            if (n == 3) fifo_empty = 4'b1111;
            tick();
            if (fifo_pop != 4'b0000) cnt_a++;
            if (push_out) begin
                cnt_b++;
                chk("lane2_word", 32'(data_out), 32'h155);
            end
        end
        chk("lane2_pops",   32'(cnt_a), 32'd1);
        chk("lane2_pushes", 32'(cnt_b), 32'd1);
        chk("lane2_idle",   32'(state), 32'd0);

        // Streaming, then downstream almost-full for 5 cycles
        fifo_empty = 4'b0000; fifo_almost_empty = 4'b0000;
        for (int n = 0; n < 6; n++) tick();
        down_almost_full = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (fifo_pop != 4'b0000) cnt_a++;
            if (push_out) cnt_b++;
        end
        chk("stall_pops",   32'(cnt_a), 32'd0);
        chk("stall_pushes", 32'(cnt_b), 32'd2);
        chk("stall_state",  32'(state), 32'd2);
        down_almost_full = 1'b0;
        for (int n = 0; n < 6; n++) tick();

        // Overflow: downstream full while words are in flight
        down_full = 1'b1;
        tick();
        chk("ovf_push",  32'(push_out), 32'd0);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_state", 32'(state), 32'd3);
        down_full = 1'b0;
        cnt_a = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (fifo_pop != 4'b0000) cnt_a++;
        end
        chk("ovf_no_pops", 32'(cnt_a), 32'd0);
        reset = 1'b0;
        tick();
        chk("ovf_rst_err",   32'(error), 32'd0);
        chk("ovf_rst_state", 32'(state), 32'd0);

        // enable low: no pops, IDLE; raising it resumes at lane 0 after reset
        reset = 1'b1; enable = 1'b0;
        cnt_a = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (fifo_pop != 4'b0000) cnt_a++;
        end
        chk("en_low_pops",  32'(cnt_a), 32'd0);
        chk("en_low_state", 32'(state), 32'd0);
        enable = 1'b1;
        tick();
        chk("en_first_pop", 32'(fifo_pop), 32'd1);
        tick(); tick();

        // Reset one cycle after a pop: in-flight words are discarded
        reset = 1'b0;
        tick();
        chk("midrst_pop",  32'(fifo_pop), 32'd0);
        chk("midrst_push", 32'(push_out), 32'd0);
        chk("midrst_data", 32'(data_out), 32'd0);
        reset = 1'b1; enable = 1'b0;
        cnt_b = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (push_out) cnt_b++;
        end
        chk("midrst_no_push", 32'(cnt_b), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            reset             = ($urandom_range(99) >= 2);
            enable            = ($urandom_range(9) != 0);
            fifo_empty        = 4'($urandom) & 4'($urandom);
            fifo_almost_empty = 4'($urandom);
            down_almost_full  = ($urandom_range(99) < 12);
            down_full         = ($urandom_range(99) < 3);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
